// File: rtl/nop_marker_inserter.sv
// nop_marker_inserter
//   Sits between fetch and decode. Every word is passed through a single
//   output register (latency 1). When insertion is enabled and a CALL or
//   RET is accepted, a marker NOP (addi NOP_RD, NOP_RS1, imm) is emitted
//   right after that instruction, carrying the same PC, with marker_o high.
//   Input is stalled while the marker is pending so nothing is lost.
//
// Ports
//   clk_i      in   1   clock, all state on rising edge
//   rst_i      in   1   synchronous active-high reset
//   flush_i    in   1   drop held word and any pending marker
//   en_i       in   1   insertion enable (0 = pure pass-through)
//   instr_i    in  32   instruction from fetch
//   pc_i       in  64   PC of instr_i
//   valid_i    in   1   input valid
//   ready_o    out  1   input ready
//   instr_o    out 32   instruction to decode
//   pc_o       out 64   PC to decode
//   valid_o    out  1   output valid
//   ready_i    in   1   output ready
//   marker_o   out  1   output word is an inserted marker
//   ins_cnt_o  out 16   number of markers emitted
//
// Configuration
//   NOP_INSERT_CNT_EN : when defined, ins_cnt_o counts emitted markers
//                       (saturating); otherwise it is tied to zero.

module nop_marker_inserter #(
    parameter logic [4:0]  NOP_RD       = 5'h00,
    parameter logic [4:0]  NOP_RS1      = 5'h00,
    parameter logic [11:0] NOP_IMM_RET  = 12'h001,
    parameter logic [11:0] NOP_IMM_CALL = 12'h002
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        en_i,
    input  logic [31:0] instr_i,
    input  logic [63:0] pc_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [31:0] instr_o,
    output logic [63:0] pc_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        marker_o,
    output logic [15:0] ins_cnt_o
);

    typedef enum logic [0:0] {
        ST_PASS   = 1'b0,
        ST_MARKER = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] instr_r;
    logic [63:0] pc_r;
    logic        valid_r;
    logic        marker_r;
    logic        mark_call_r;
    logic        ready_s;
    logic        in_xfer_s;
    logic        out_xfer_s;
    logic        is_call_s;
    logic        is_ret_s;

    // RET is exactly jalr x0, 0(x1)
    function automatic logic is_ret_f(input logic [31:0] w);
        return (w[6:0] == 7'b1100111) && (w[14:12] == 3'b000) &&
               (w[11:7] == 5'd0) && (w[19:15] == 5'd1) && (w[31:20] == 12'd0);
    endfunction

    // CALL is any JAL, or JALR with funct3 0, that links into a non-zero rd
    function automatic logic is_call_f(input logic [31:0] w);
        return ((w[6:0] == 7'b1101111) ||
                ((w[6:0] == 7'b1100111) && (w[14:12] == 3'b000))) &&
               (w[11:7] != 5'd0);
    endfunction

    function automatic logic [31:0] marker_word_f(input logic call);
        logic [11:0] imm;
        imm = call ? NOP_IMM_CALL : NOP_IMM_RET;
        return {imm, NOP_RS1, 3'b000, NOP_RD, 7'b0010011};
    endfunction

    assign is_call_s  = is_call_f(instr_i);
    assign is_ret_s   = is_ret_f(instr_i);
    assign in_xfer_s  = valid_i && ready_s;
    assign out_xfer_s = valid_r && ready_i;

    // FSM state register; reset and flush both return to PASS
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state_r <= ST_PASS;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; en_i matters only at the moment a CALL/RET is accepted
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_PASS: begin
                if (in_xfer_s && en_i && (is_call_s || is_ret_s)) begin
                    state_next_s = ST_MARKER;
                end else begin
                    state_next_s = ST_PASS;
                end
            end
            ST_MARKER: begin
                if (out_xfer_s) begin
                    state_next_s = ST_PASS;
                end else begin
                    state_next_s = ST_MARKER;
                end
            end
            default: state_next_s = ST_PASS;
        endcase
    end

    // FSM outputs; input is blocked while the marker waits for its slot
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            ST_PASS:   ready_s = !valid_r || ready_i;
            ST_MARKER: ready_s = 1'b0;
            default:   ready_s = 1'b0;
        endcase
    end

    // Output register: load accepted words, or the marker once its CALL/RET leaves
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_r     <= 32'h0000_0000;
            pc_r        <= 64'h0;
            valid_r     <= 1'b0;
            marker_r    <= 1'b0;
            mark_call_r <= 1'b0;
        end else if (flush_i) begin
            valid_r  <= 1'b0;
            marker_r <= 1'b0;
        end else begin
            case (state_r)
                ST_PASS: begin
                    if (in_xfer_s) begin
                        instr_r     <= instr_i;
                        pc_r        <= pc_i;
                        valid_r     <= 1'b1;
                        marker_r    <= 1'b0;
                        mark_call_r <= is_call_s;
                    end else if (out_xfer_s) begin
                        valid_r  <= 1'b0;
                        marker_r <= 1'b0;
                    end
                end
                ST_MARKER: begin
                    // pc_r keeps the CALL/RET PC, which the marker reuses
                    if (out_xfer_s) begin
                        instr_r  <= marker_word_f(mark_call_r);
                        valid_r  <= 1'b1;
                        marker_r <= 1'b1;
                    end
                end
                default: begin
                    valid_r  <= 1'b0;
                    marker_r <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o  = ready_s;
    assign instr_o  = instr_r;
    assign pc_o     = pc_r;
    assign valid_o  = valid_r;
    assign marker_o = marker_r;

`ifdef NOP_INSERT_CNT_EN
    logic [15:0] cnt_r;

    // Saturating count of markers handed to decode; flush does not clear it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= 16'h0000;
        end else if (!flush_i && out_xfer_s && marker_r && (cnt_r != 16'hFFFF)) begin
            cnt_r <= cnt_r + 16'h0001;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign ins_cnt_o = cnt_r;
`else
    assign ins_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_nop_marker_inserter.sv
module tb_nop_marker_inserter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        en_i = 1'b0;
    logic [31:0] instr_i = 32'h0;
    logic [63:0] pc_i = 64'h0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] instr_o;
    logic [63:0] pc_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        marker_o;
    logic [15:0] ins_cnt_o;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        mk;
    } item_t;
    item_t sb[$];

    localparam logic [31:0] MK_RET  = 32'h00100013;
    localparam logic [31:0] MK_CALL = 32'h00200013;

    nop_marker_inserter dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .en_i(en_i),
        .instr_i(instr_i), .pc_i(pc_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_o(instr_o), .pc_o(pc_o), .valid_o(valid_o), .ready_i(ready_i),
        .marker_o(marker_o), .ins_cnt_o(ins_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit tb_is_ret(input logic [31:0] w);
        return w == 32'h00008067;
    endfunction

    function automatic bit tb_is_call(input logic [31:0] w);
        return ((w[6:0] == 7'h6F) || ((w[6:0] == 7'h67) && (w[14:12] == 3'd0))) &&
               (w[11:7] != 5'd0);
    endfunction

    function automatic logic [15:0] exp_ins_cnt();
`ifdef NOP_INSERT_CNT_EN
        return exp_cnt[15:0];
`else
        return 16'h0000;
`endif
    endfunction

    // Scoreboard: sample mid-cycle the transfers that the next rising edge will perform
    always @(negedge clk) begin
        item_t it;
        if (rst_i) begin
            sb.delete();
            exp_cnt = 0;
        end else if (flush_i) begin
            sb.delete();
        end else begin
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", {32'h0, instr_o}, 64'hDEAD);
                end else begin
                    it = sb.pop_front();
                    check_eq("out_instr", {32'h0, instr_o}, {32'h0, it.instr});
                    check_eq("out_pc", pc_o, it.pc);
                    check_eq("out_marker", {63'h0, marker_o}, {63'h0, it.mk});
                    if (it.mk) exp_cnt++;
                end
            end
            if (valid_i && ready_o) begin
                sb.push_back('{instr_i, pc_i, 1'b0});
                if (en_i && tb_is_ret(instr_i))  sb.push_back('{MK_RET, pc_i, 1'b1});
                if (en_i && tb_is_call(instr_i)) sb.push_back('{MK_CALL, pc_i, 1'b1});
            end
        end
    end

    // Drive one word; returns at posedge+1 after the edge that accepted it
    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        bit acc = 1'b0;
        instr_i = ins;
        pc_i    = pc;
        valid_i = 1'b1;
        for (int n = 0; n < 200; n++) begin
            if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = ready_o;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        valid_i = 1'b0;
        if (!acc) check_eq("send_timeout", 64'h0, 64'h1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] tbl [8] = '{32'h000080E7, 32'h00008067, 32'h000000EF, 32'h0000006F,
                             32'h00000067, 32'h00B50533, 32'h00008066, 32'h00A08067};

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", {63'h0, valid_o}, 64'h0);
        check_eq("rst_marker", {63'h0, marker_o}, 64'h0);
        check_eq("rst_instr", {32'h0, instr_o}, 64'h0);
        check_eq("rst_pc", pc_o, 64'h0);
        check_eq("rst_cnt", {48'h0, ins_cnt_o}, 64'h0);
        rst_i = 1'b0;
        en_i  = 1'b1;
        idle(1);

        // jalr ra,0(ra) -> call marker with same PC
        send(32'h000080E7, 64'h1000);
        idle(4);

        // ret -> ret marker, input stalls exactly one cycle
        send(32'h00008067, 64'h2000);
        check_eq("ret_ready_low", {63'h0, ready_o}, 64'h0);
        idle(1);
        check_eq("ret_ready_back", {63'h0, ready_o}, 64'h1);
        check_eq("ret_mk_word", {32'h0, instr_o}, {32'h0, MK_RET});
        idle(3);

        // Insertion disabled: pure pass-through
        en_i = 1'b0;
        send(32'h00008067, 64'h2100);
        send(32'h000000EF, 64'h2104);
        idle(4);
        check_eq("en0_cnt", {48'h0, ins_cnt_o}, {48'h0, exp_ins_cnt()});
        en_i = 1'b1;

        // Output stall with a call held
        ready_i = 1'b0;
        send(32'h000000EF, 64'h3000);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_instr", {32'h0, instr_o}, 64'h000000EF);
            check_eq("stall_valid", {63'h0, valid_o}, 64'h1);
            check_eq("stall_ready", {63'h0, ready_o}, 64'h0);
            idle(1);
        end
        ready_i = 1'b1;
        idle(1);
        check_eq("stall_mk_flag", {63'h0, marker_o}, 64'h1);
        check_eq("stall_mk_word", {32'h0, instr_o}, {32'h0, MK_CALL});
        check_eq("stall_mk_pc", pc_o, 64'h3000);
        idle(3);

        // Flush while a marker is pending
        ready_i = 1'b0;
        send(32'h000080E7, 64'h4000);
        flush_i = 1'b1;
        idle(1);
        flush_i = 1'b0;
        check_eq("flush_valid", {63'h0, valid_o}, 64'h0);
        check_eq("flush_ready", {63'h0, ready_o}, 64'h1);
        ready_i = 1'b1;
        idle(2);
        check_eq("flush_no_mk", {63'h0, valid_o}, 64'h0);
        send(32'h00008067, 64'h4100);
        idle(4);
        check_eq("flush_cnt", {48'h0, ins_cnt_o}, {48'h0, exp_ins_cnt()});

        // Random mix with back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            en_i = ($urandom_range(0, 3) != 0);
            send(tbl[$urandom_range(0, 7)], 64'h8000 + 64'(i * 4));
        end
        rand_rdy = 1'b0;
        ready_i  = 1'b1;
        en_i     = 1'b1;
        idle(5);
        for (int i = 0; i < 4; i++) send((i % 2 == 0) ? 32'h000000EF : 32'h00008067, 64'h9000 + 64'(i * 4));
        idle(5);

        // Reset in the middle of a pending marker
        ready_i = 1'b0;
        send(32'h000080E7, 64'h5000);
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
        ready_i = 1'b1;
        check_eq("rst2_valid", {63'h0, valid_o}, 64'h0);
        check_eq("rst2_cnt", {48'h0, ins_cnt_o}, 64'h0);

        // 3 calls + 2 rets, then jal x0 gets no marker
        send(32'h000000EF, 64'h6000);
        send(32'h00008067, 64'h6004);
        send(32'h000080E7, 64'h6008);
        send(32'h00008067, 64'h600C);
        send(32'h000000EF, 64'h6010);
        send(32'h0000006F, 64'h6014);
        idle(5);
`ifdef NOP_INSERT_CNT_EN
        check_eq("cnt_five", {48'h0, ins_cnt_o}, 64'd5);
`else
        check_eq("cnt_zero", {48'h0, ins_cnt_o}, 64'd0);
`endif
        check_eq("sb_empty", 64'(sb.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nop_marker_inserter.md
NOP_MARKER_INSERTER -- requirements
Module: nop_marker_inserter

Interface
REQ-001 SHALL have parameter NOP_RD, default 5'h0, rd field of the inserted marker.
REQ-002 SHALL have parameter NOP_RS1, default 5'h0, rs1 field of the inserted marker.
REQ-003 SHALL have parameter NOP_IMM_RET, default 12'h001, marker immediate after a return.
REQ-004 SHALL have parameter NOP_IMM_CALL, default 12'h002, marker immediate after a call.
REQ-005 SHALL have one clock and a synchronous, active-high reset; clk_i  in  1  clock, all state on rising edge.
REQ-006 SHALL have rst_i  in  1  synchronous active-high reset.
REQ-007 SHALL have flush_i  in  1  discard all buffered and pending instructions.
REQ-008 SHALL have en_i  in  1  insertion enable (CSR); 0 = pure pass-through.
REQ-009 SHALL have instr_i  in  32  uncompressed instruction from fetch.
REQ-010 SHALL have pc_i  in  64  PC of instr_i.
REQ-011 SHALL have valid_i  in  1 and ready_o  out  1  input handshake.
REQ-012 SHALL have instr_o  out  32, pc_o  out  64  instruction and PC to decode.
REQ-013 SHALL have valid_o  out  1 and ready_i  in  1  output handshake.
REQ-014 SHALL have marker_o  out  1  high while the output word is an inserted marker.
REQ-015 SHALL have ins_cnt_o  out  16  number of markers inserted (see Configuration).

Function
REQ-016 SHALL transfer on input when valid_i && ready_o, on output when valid_o && ready_i.
REQ-017 SHALL hold one output register; an accepted word appears on the outputs the next cycle (latency 1).
REQ-018 SHALL classify RET: opcode 7'b1100111, funct3 3'b000, rd=0, rs1=1, imm=0.
REQ-019 SHALL classify CALL: (opcode 7'b1101111) or (opcode 7'b1100111 with funct3 3'b000), and rd != 0.
REQ-020 SHALL not classify JAL/JALR with rd=0 (other than RET), or words with instr_i[1:0] != 2'b11.
REQ-021 SHALL run FSM PASS/MARKER; reset and flush enter PASS.
REQ-022 In PASS SHALL drive ready_o = !valid_o || ready_i.
REQ-023 In PASS, accepting a CALL or RET with en_i=1 SHALL latch the marker type and move to MARKER; en_i is sampled only at that acceptance.
REQ-024 In MARKER SHALL drive ready_o = 0; when the held CALL/RET leaves (valid_o && ready_i), SHALL load the marker into the output register and return to PASS.
REQ-025 The marker word SHALL be {imm,NOP_RS1,3'b000,NOP_RD,7'b0010011}, imm per REQ-003/004; defaults give 32'h00100013 (RET) and 32'h00200013 (CALL).
REQ-026 The marker pc_o SHALL equal the PC of the preceding CALL/RET; marker_o=1 only for the marker.
REQ-027 Output registers SHALL hold stable while valid_o && !ready_i.
REQ-028 Marker output SHALL never be classified or followed by another marker.
REQ-029 Back-to-back CALL/RET SHALL produce CALL, marker, CALL, marker with no word lost or reordered.
REQ-030 flush_i SHALL clear valid_o and the pending marker in the same edge and take priority over any simultaneous transfer; ins_cnt_o SHALL not be cleared.

Reset
REQ-031 On rst_i: valid_o=0, marker_o=0, instr_o=0, pc_o=0, ins_cnt_o=0, FSM=PASS.
REQ-032 Reset asserted mid-MARKER SHALL drop the pending marker; the first post-reset word SHALL be treated fresh.

Configuration
REQ-033 With NOP_INSERT_CNT_EN defined, ins_cnt_o SHALL increment by 1 on each marker output transfer, saturating at 16'hFFFF.
REQ-034 Without NOP_INSERT_CNT_EN, ins_cnt_o SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-035 en_i=1, ready_i=1, feed 32'h000080E7 (jalr ra,0(ra)) pc 0x1000 -> out 0x000080E7 then 0x00200013, marker_o=1, pc_o=0x1000.
REQ-036 en_i=1, feed 32'h00008067 (ret) -> out 0x00008067 then 0x00100013; ready_o low one cycle.
REQ-037 en_i=0, feed ret then call -> outputs identical to inputs, no marker, ins_cnt_o stays 0.
REQ-038 ready_i=0 for 5 cycles with call held -> outputs stable, ready_o=0, marker follows one cycle after ready_i rises.
REQ-039 flush_i asserted while in MARKER -> valid_o=0 next cycle, no marker emitted, next ret gets fresh marker.
REQ-040 NOP_INSERT_CNT_EN defined, 3 calls + 2 rets -> ins_cnt_o=5; JAL x0 (32'h0000006F) -> no marker.
